// File: rtl/key_step_pkg.sv
// rtl/key_step_pkg.sv - shared types and helpers for the key conditioning / step clock block
//
// Purpose: mode and step-FSM enums, a counter-width helper, and the mode decoder
//          used by key_step_ctrl and key_debounce.
// Ports:   none (package).
// Options: none here; the KEY_STEP_COUNT_EN macro is consumed by key_step_ctrl.

package key_step_pkg;

   typedef enum logic [1:0] {
      MODE_STEP  = 2'b00,
      MODE_RUN   = 2'b01,
      MODE_BURST = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HI   = 2'b01,
      ST_LO   = 2'b10
   } state_e;

   // Bits needed for a counter that runs 0 .. n-1 (never narrower than 1 bit).
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // The reserved encoding 2'b11 behaves as single step.
   function automatic mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'b01:   return MODE_RUN;
         2'b10:   return MODE_BURST;
         default: return MODE_STEP;
      endcase
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key channel: 2-flop synchroniser, debounce counter, edge strobes
//
// Purpose: accepts a level change only after the synchronised input has differed
//          from the current level for DEBOUNCE_CYCLES consecutive samples.
// Ports:
//   Clk_i      board clock
//   Reset_i    asynchronous active-high reset
//   KeyIn_i    raw key level, asynchronous to Clk_i
//   Level_o    debounced level
//   Press_o    one-cycle strobe, issued together with a rising Level_o
//   Release_o  one-cycle strobe, issued together with a falling Level_o

module key_debounce
   import key_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic Clk_i,
   input  logic Reset_i,
   input  logic KeyIn_i,
   output logic Level_o,
   output logic Press_o,
   output logic Release_o
);

   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;
   logic          release_q, release_d;

   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         level_q   <= 1'b0;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= KeyIn_i;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // Any sample matching the current level restarts the count, so a glitch
   // shorter than the debounce window never reaches Level_o.
   always_comb begin
      level_d   = level_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d   = sync2_q;
            press_d   = sync2_q;
            release_d = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign Level_o   = level_q;
   assign Press_o   = press_q;
   assign Release_o = release_q;

endmodule

// File: rtl/key_step_ctrl.sv
// rtl/key_step_ctrl.sv - key conditioning plus manual processor step clock generator
//
// Purpose: conditions NUM_KEYS push buttons and, from the key-0 press strobe,
//          drives StepClk in single-step, continuous-run or burst mode.
// Ports:
//   Clk_i         board clock
//   Reset_i       asynchronous active-high reset; all outputs drop at once
//   KeyIn_i       raw active-high key levels
//   Mode_i        00 step, 01 run, 10 burst, 11 treated as step
//   BurstLen_i    pulses per burst trigger (0 = trigger ignored)
//   Level_o       debounced key levels
//   Press_o       per-key rising strobes
//   Release_o     per-key falling strobes
//   StepClk_o     generated processor clock, registered
//   StepStrobe_o  one-cycle strobe on each StepClk rising edge
//   Busy_o        high while a pulse sequence is in progress
//   StepCount_o   step counter, only built with KEY_STEP_COUNT_EN (else 0)
// Options: `define KEY_STEP_COUNT_EN to build the 16-bit wrapping step counter.

module key_step_ctrl
   import key_step_pkg::*;
#(
   parameter int NUM_KEYS        = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HALF_CYCLES     = 2500000,
   parameter int BURST_W         = 8
) (
   input  logic                Clk_i,
   input  logic                Reset_i,
   input  logic [NUM_KEYS-1:0] KeyIn_i,
   input  logic [1:0]          Mode_i,
   input  logic [BURST_W-1:0]  BurstLen_i,
   output logic [NUM_KEYS-1:0] Level_o,
   output logic [NUM_KEYS-1:0] Press_o,
   output logic [NUM_KEYS-1:0] Release_o,
   output logic                StepClk_o,
   output logic                StepStrobe_o,
   output logic                Busy_o,
   output logic [15:0]         StepCount_o
);

   localparam int HW = cnt_w(HALF_CYCLES);
   localparam logic [HW-1:0] HALF_MAX = HW'(HALF_CYCLES - 1);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .Clk_i    (Clk_i),
         .Reset_i  (Reset_i),
         .KeyIn_i  (KeyIn_i[g]),
         .Level_o  (Level_o[g]),
         .Press_o  (Press_o[g]),
         .Release_o(Release_o[g])
      );
   end

   logic step_key;
   assign step_key = Press_o[0];

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [HW-1:0]    hcnt_q, hcnt_d;
   logic [BURST_W:0] rem_q, rem_d, rem_next;
   logic             run_q, run_d;
   logic             stop_q, stop_d;
   logic             stepclk_q, stepclk_d;
   logic             strobe_q, strobe_d;
   logic             busy_q, busy_d;
   logic             half_done;

   // State register
   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_STEP;
         hcnt_q    <= '0;
         rem_q     <= '0;
         run_q     <= 1'b0;
         stop_q    <= 1'b0;
         stepclk_q <= 1'b0;
         strobe_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         hcnt_q    <= hcnt_d;
         rem_q     <= rem_d;
         run_q     <= run_d;
         stop_q    <= stop_d;
         stepclk_q <= stepclk_d;
         strobe_q  <= strobe_d;
         busy_q    <= busy_d;
      end
   end

   assign half_done = (hcnt_q == HALF_MAX);

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      hcnt_d   = hcnt_q;
      rem_d    = rem_q;
      run_d    = run_q;
      stop_d   = stop_q;
      rem_next = run_q ? rem_q : rem_q - 1'b1;
      case (state_q)
         ST_IDLE: begin
            // Mode follows the input only while idle; it is frozen once busy.
            mode_d = decode_mode(Mode_i);
            hcnt_d = '0;
            run_d  = 1'b0;
            stop_d = 1'b0;
            if (step_key) begin
               case (decode_mode(Mode_i))
                  MODE_RUN: begin
                     run_d   = 1'b1;
                     state_d = ST_HI;
                  end
                  MODE_BURST: begin
                     if (BurstLen_i != '0) begin
                        rem_d   = {1'b0, BurstLen_i};
                        state_d = ST_HI;
                     end
                  end
                  default: begin
                     rem_d   = (BURST_W + 1)'(1);
                     state_d = ST_HI;
                  end
               endcase
            end
         end
         ST_HI: begin
            if (step_key && mode_q != MODE_STEP) stop_d = 1'b1;
            if (half_done) begin
               hcnt_d  = '0;
               state_d = ST_LO;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         ST_LO: begin
            if (step_key && mode_q != MODE_STEP) stop_d = 1'b1;
            if (half_done) begin
               hcnt_d = '0;
               rem_d  = rem_next;
               // A pending stop wins over the run flag so RUN can be ended;
               // a stop pressed in this very cycle is honoured too.
               if (!stop_d && (run_q || rem_next != '0)) begin
                  state_d = ST_HI;
               end else begin
                  state_d = ST_IDLE;
                  run_d   = 1'b0;
                  stop_d  = 1'b0;
               end
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: decoded from the next state so every output is a flop.
   always_comb begin
      stepclk_d = (state_d == ST_HI);
      strobe_d  = (state_d == ST_HI) && (state_q != ST_HI);
      busy_d    = (state_d != ST_IDLE);
   end

   assign StepClk_o    = stepclk_q;
   assign StepStrobe_o = strobe_q;
   assign Busy_o       = busy_q;

`ifdef KEY_STEP_COUNT_EN
   logic [15:0] step_count_q;

   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         step_count_q <= '0;
      end else if (strobe_q) begin
         step_count_q <= step_count_q + 16'd1;
      end
   end

   assign StepCount_o = step_count_q;
`else
   assign StepCount_o = '0;
`endif

endmodule

// File: tb/tb_key_step_ctrl.sv
// tb/tb_key_step_ctrl.sv - self-checking bench for key_step_ctrl

module tb_key_step_ctrl;

   localparam int NK = 2;
   localparam int D  = 4;
   localparam int H  = 3;
   localparam int BW = 8;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic [NK-1:0] KeyIn = '0;
   logic [1:0]    Mode = 2'b00;
   logic [BW-1:0] BurstLen = '0;
   logic [NK-1:0] Level, Press, Release;
   logic          StepClk, StepStrobe, Busy;
   logic [15:0]   StepCount;

   key_step_ctrl #(
      .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .HALF_CYCLES(H), .BURST_W(BW)
   ) dut (
      .Clk_i(Clk), .Reset_i(Reset), .KeyIn_i(KeyIn), .Mode_i(Mode),
      .BurstLen_i(BurstLen), .Level_o(Level), .Press_o(Press),
      .Release_o(Release), .StepClk_o(StepClk), .StepStrobe_o(StepStrobe),
      .Busy_o(Busy), .StepCount_o(StepCount)
   );

   always #5 Clk = ~Clk;

   // Behavioural model: debounce as a run-length of disagreeing samples, step
   // generator as a phase within a 2*H period plus a count of pulses left.
   logic [NK-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_press = '0, m_rel = '0;
   int            m_run [NK];
   bit            m_active = 0, m_runf = 0, m_stop = 0;
   int            m_ph = 0, m_left = 0, m_mode = 0;
   logic [15:0]   m_cnt = '0;

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
         for (int k = 0; k < NK; k++) m_run[k] = 0;
         m_active = 0; m_runf = 0; m_stop = 0; m_ph = 0; m_left = 0; m_mode = 0;
         m_cnt = '0;
      end else begin
         if (m_active && m_ph == 0) m_cnt = m_cnt + 16'd1;
         if (!m_active) begin
            m_stop = 0;
            m_runf = 0;
            if (m_press[0]) begin
               m_mode = (Mode == 2'b11) ? 0 : int'(Mode);
               m_ph = 0;
               if (m_mode == 0) begin
                  m_active = 1; m_left = 1;
               end else if (m_mode == 1) begin
                  m_active = 1; m_runf = 1;
               end else if (BurstLen != 0) begin
                  m_active = 1; m_left = int'(BurstLen);
               end
            end
         end else begin
            if (m_press[0] && m_mode != 0) m_stop = 1;
            m_ph++;
            if (m_ph == 2 * H) begin
               if (!m_runf) m_left--;
               if (!m_stop && (m_runf || m_left > 0)) m_ph = 0;
               else m_active = 0;
            end
         end
         for (int k = 0; k < NK; k++) begin
            m_press[k] = 1'b0;
            m_rel[k]   = 1'b0;
            if (m_s2[k] != m_lvl[k]) m_run[k]++;
            else m_run[k] = 0;
            if (m_run[k] == D) begin
               m_lvl[k]   = m_s2[k];
               m_press[k] = m_s2[k];
               m_rel[k]   = ~m_s2[k];
               m_run[k]   = 0;
            end
            m_s2[k] = m_s1[k];
            m_s1[k] = KeyIn[k];
         end
      end
   end

   int          vecs = 0, errs = 0;
   int          cyc_n = 0;
   int          c_strobe = 0, c_hi = 0, c_busy = 0, c_press0 = 0, c_press1 = 0, c_rel1 = 0;
   int          strobe_t[$];
   logic [15:0] ofs = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc_n);
      end
   endtask

   task automatic cmp_all();
      logic [15:0] exp_cnt;
`ifdef KEY_STEP_COUNT_EN
      exp_cnt = m_cnt + ofs;
`else
      exp_cnt = 16'h0;
`endif
      chk("level",   32'(Level),   32'(m_lvl));
      chk("press",   32'(Press),   32'(m_press));
      chk("release", 32'(Release), 32'(m_rel));
      chk("stepclk", 32'(StepClk), 32'(m_active && m_ph < H));
      chk("strobe",  32'(StepStrobe), 32'(m_active && m_ph == 0));
      chk("busy",    32'(Busy),    32'(m_active));
      chk("count",   32'(StepCount), 32'(exp_cnt));
      c_strobe += int'(StepStrobe);
      c_hi     += int'(StepClk);
      c_busy   += int'(Busy);
      c_press0 += int'(Press[0]);
      c_press1 += int'(Press[1]);
      c_rel1   += int'(Release[1]);
      if (StepStrobe) strobe_t.push_back(cyc_n);
   endtask

   // One clock: compare at the falling edge, return 1 time unit after the rising edge.
   task automatic cyc();
      @(negedge Clk);
      if (!Reset) cmp_all();
      @(posedge Clk);
      cyc_n++;
      #1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic press0(input int hold);
      KeyIn[0] = 1'b1;
      tick(hold);
      KeyIn[0] = 1'b0;
   endtask

   int s_strobe, s_hi, s_busy, s_p, s_r, lat, qs;

   initial begin
      #1;
      chk("rst_stepclk", 32'(StepClk), 32'd0);
      chk("rst_busy",    32'(Busy), 32'd0);
      chk("rst_strobe",  32'(StepStrobe), 32'd0);
      chk("rst_level",   32'(Level), 32'd0);
      chk("rst_count",   32'(StepCount), 32'd0);
      tick(2);
      Reset = 1'b0;
      tick(2);

      // Bounce: 3 high samples are one short of acceptance.
      s_p = c_press0;
      KeyIn[0] = 1'b1;
      tick(3);
      KeyIn[0] = 1'b0;
      tick(12);
      chk("bounce_press", 32'(c_press0 - s_p), 32'd0);
      chk("bounce_level", 32'(Level[0]), 32'd0);

      // Clean press and release on key 1: 2 sync + 4 debounce edges.
      s_p = c_press1; lat = 0;
      KeyIn[1] = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         cyc();
         if (Level[1] && lat == 0) lat = n;
      end
      chk("press1_latency", 32'(lat), 32'd6);
      chk("press1_count", 32'(c_press1 - s_p), 32'd1);
      s_r = c_rel1; lat = 0;
      KeyIn[1] = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         cyc();
         if (!Level[1] && lat == 0) lat = n;
      end
      chk("release1_latency", 32'(lat), 32'd6);
      chk("release1_count", 32'(c_rel1 - s_r), 32'd1);

      // STEP mode: one full pulse.
      Mode = 2'b00;
      s_strobe = c_strobe; s_hi = c_hi; s_busy = c_busy;
      press0(8);
      tick(20);
      chk("step_strobes", 32'(c_strobe - s_strobe), 32'd1);
      chk("step_hi",      32'(c_hi - s_hi), 32'd3);
      chk("step_busy",    32'(c_busy - s_busy), 32'd6);

      // BURST of 3; BurstLen changed mid-burst must not matter.
      Mode = 2'b10; BurstLen = 8'd3;
      s_strobe = c_strobe; s_busy = c_busy; qs = strobe_t.size();
      press0(8);
      BurstLen = 8'd7;
      tick(30);
      chk("burst_strobes", 32'(c_strobe - s_strobe), 32'd3);
      chk("burst_busy",    32'(c_busy - s_busy), 32'd18);
      chk("burst_gap1", (strobe_t.size() >= qs + 3) ? 32'(strobe_t[qs+1] - strobe_t[qs]) : 32'hFFFF_FFFF, 32'd6);
      chk("burst_gap2", (strobe_t.size() >= qs + 3) ? 32'(strobe_t[qs+2] - strobe_t[qs+1]) : 32'hFFFF_FFFF, 32'd6);

      // BURST with length 0: trigger ignored.
      BurstLen = 8'd0;
      s_strobe = c_strobe; s_busy = c_busy;
      press0(8);
      tick(20);
      chk("burst0_strobes", 32'(c_strobe - s_strobe), 32'd0);
      chk("burst0_busy",    32'(c_busy - s_busy), 32'd0);

      // RUN: stop press lands in the 7th pulse, which still completes.
      Mode = 2'b01;
      s_strobe = c_strobe; s_hi = c_hi; s_busy = c_busy;
      press0(8);
      Mode = 2'b10;
      tick(30);
      press0(8);
      tick(20);
      chk("run_strobes", 32'(c_strobe - s_strobe), 32'd7);
      chk("run_hi",      32'(c_hi - s_hi), 32'd21);
      chk("run_busy",    32'(c_busy - s_busy), 32'd42);
      chk("run_end_clk", 32'(StepClk), 32'd0);
      chk("run_end_busy", 32'(Busy), 32'd0);

      // Reset in the 2nd HI cycle drops outputs without a clock edge.
      Mode = 2'b00;
      KeyIn[0] = 1'b1;
      lat = 0;
      for (int n = 0; n < 20 && lat == 0; n++) begin
         cyc();
         if (StepClk) lat = 1;
      end
      chk("hi_reached", 32'(lat), 32'd1);
      cyc();
      chk("pre_rst_clk", 32'(StepClk), 32'd1);
      Reset = 1'b1;
      #1;
      chk("async_rst_clk",   32'(StepClk), 32'd0);
      chk("async_rst_busy",  32'(Busy), 32'd0);
      chk("async_rst_count", 32'(StepCount), 32'd0);
      chk("async_rst_level", 32'(Level), 32'd0);
      KeyIn[0] = 1'b0;
      tick(2);
      Reset = 1'b0;
      tick(4);

`ifdef KEY_STEP_COUNT_EN
      force dut.step_count_q = 16'hFFFE;
      #1;
      release dut.step_count_q;
      ofs = 16'hFFFE - m_cnt;
      press0(8);
      tick(20);
      chk("wrap_ffff", 32'(StepCount), 32'h0000_FFFF);
      press0(8);
      tick(20);
      chk("wrap_0000", 32'(StepCount), 32'h0000_0000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
